fpu_sequencer: RTL and testbench

- Issue/completion controller between the FP decode stage and the FP execute unit.
- Accepts one decoded FP operation at a time and resolves the dynamic rounding mode from frm.
- Starts the execute unit, waits for its result (variable latency: single-cycle sgnj/cmp up to multi-cycle fdiv/fsqrt), then presents a registered writeback beat.
- Owns the fcsr state (frm, fflags), its CSR read/write port, and accumulation of exception flags.

---
 rtl/fpu_sequencer_pkg.sv | 48 ++++
 rtl/fp_csr_file.sv | 47 ++++
 rtl/fpu_sequencer.sv | 132 +++++++++++++
 tb/tb_fpu_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_sequencer_pkg.sv
// fpu_sequencer_pkg: shared constants and types for the FP issue/completion sequencer.
package fp_cons;
    localparam logic [11:0] CSR_FFLAGS = 12'h001;
    localparam logic [11:0] CSR_FRM    = 12'h002;
    localparam logic [11:0] CSR_FCSR   = 12'h003;
    localparam logic [2:0]  RM_RNE = 3'd0;
    localparam logic [2:0]  RM_RTZ = 3'd1;
    localparam logic [2:0]  RM_RDN = 3'd2;
    localparam logic [2:0]  RM_RUP = 3'd3;
    localparam logic [2:0]  RM_RMM = 3'd4;
    localparam logic [2:0]  RM_DYN = 3'd7;
endpackage

package fp_wire;
    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} fp_seq_state_type;

    typedef struct packed {
        logic        issue_valid;
        logic        issue_userm;
        logic        issue_fpuf;
        logic [2:0]  issue_rm;
        logic [4:0]  issue_waddr;
        logic        issue_wren;
        logic        issue_fwren;
        logic        kill;
        logic        exe_ready;
        logic [31:0] exe_result;
        logic [4:0]  exe_flags;
        logic        csr_wen;
        logic [11:0] csr_addr;
        logic [31:0] csr_wdata;
    } fp_seq_in_type;

    typedef struct packed {
        logic        issue_ready;
        logic        exe_enable;
        logic [2:0]  exe_rm;
        logic        wb_valid;
        logic [31:0] wb_data;
        logic [4:0]  wb_waddr;
        logic        wb_wren;
        logic        wb_fwren;
        logic        illegal;
        logic [31:0] csr_rdata;
        logic [2:0]  frm;
        logic [4:0]  fflags;
    } fp_seq_out_type;
endpackage

// File: rtl/fp_csr_file.sv
// fp_csr_file: frm/fflags storage, CSR write priority over flag accumulation, and read mux.
module fp_csr_file
    import fp_cons::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_wen,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic        acc_en,
    input  logic [4:0]  acc_flags,
    output logic [2:0]  frm,
    output logic [4:0]  fflags,
    output logic [31:0] csr_rdata
);
    logic [2:0] frm_q, frm_d;
    logic [4:0] fflags_q, fflags_d;
    logic       wr_ff, wr_frm, wr_fcsr;
    logic       unused_wdata;

    assign wr_ff        = csr_wen & (csr_addr == CSR_FFLAGS);
    assign wr_frm       = csr_wen & (csr_addr == CSR_FRM);
    assign wr_fcsr      = csr_wen & (csr_addr == CSR_FCSR);
    assign unused_wdata = ^csr_wdata[31:8];

    // an explicit fflags/fcsr write overrides flags completing in the same cycle
    always_comb begin
        fflags_d = (wr_ff | wr_fcsr) ? csr_wdata[4:0] : acc_en ? (fflags_q | acc_flags) : fflags_q;
        frm_d    = wr_frm ? csr_wdata[2:0] : wr_fcsr ? csr_wdata[7:5] : frm_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frm_q    <= '0;
            fflags_q <= '0;
        end else begin
            frm_q    <= frm_d;
            fflags_q <= fflags_d;
        end
    end

    assign frm       = frm_q;
    assign fflags    = fflags_q;
    assign csr_rdata = (csr_addr == CSR_FFLAGS) ? {27'b0, fflags_q} :
                       (csr_addr == CSR_FRM)    ? {29'b0, frm_q} :
                       (csr_addr == CSR_FCSR)   ? {24'b0, frm_q, fflags_q} : 32'b0;
endmodule

// File: rtl/fpu_sequencer.sv
// fpu_sequencer: issues one FP op at a time to the execute unit, resolves dynamic rm,
// and returns a registered writeback beat while accumulating exception flags.
module fpu_sequencer
    import fp_cons::*;
    import fp_wire::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic        issue_userm,
    input  logic        issue_fpuf,
    input  logic [2:0]  issue_rm,
    input  logic [4:0]  issue_waddr,
    input  logic        issue_wren,
    input  logic        issue_fwren,
    input  logic        kill,
    output logic        exe_enable,
    output logic [2:0]  exe_rm,
    input  logic        exe_ready,
    input  logic [31:0] exe_result,
    input  logic [4:0]  exe_flags,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_waddr,
    output logic        wb_wren,
    output logic        wb_fwren,
    output logic        illegal,
    input  logic        csr_wen,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic [2:0]  frm,
    output logic [4:0]  fflags
);
    fp_seq_state_type state_q, state_d;
    logic [2:0]  exe_rm_q, exe_rm_d, rr;
    logic [4:0]  waddr_q, waddr_d;
    logic        wren_q, wren_d, fwren_q, fwren_d, fpuf_q, fpuf_d;
    logic        wb_valid_q, wb_valid_d, illegal_q, illegal_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        hs, bad_rm, accept, acc_en;

    assign issue_ready = (state_q == IDLE) & ~kill;
    assign rr          = (issue_rm == RM_DYN) ? frm : issue_rm;
    assign bad_rm      = issue_userm & (rr > RM_RMM);
    assign hs          = issue_valid & issue_ready;
    assign accept      = hs & ~bad_rm;

    always_comb begin
        state_d    = state_q;
        exe_rm_d   = exe_rm_q;
        waddr_d    = waddr_q;
        wren_d     = wren_q;
        fwren_d    = fwren_q;
        fpuf_d     = fpuf_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        acc_en     = 1'b0;
        illegal_d  = hs & bad_rm;
        case (state_q)
            IDLE: if (accept) begin
                exe_rm_d   = rr;
                waddr_d    = issue_waddr;
                wren_d     = issue_wren;
                fwren_d    = issue_fwren;
                fpuf_d     = issue_fpuf;
                state_d    = exe_ready ? IDLE : WAIT;
                wb_valid_d = exe_ready;
                wb_data_d  = exe_ready ? exe_result : wb_data_q;
                acc_en     = exe_ready & issue_fpuf;
            end
            WAIT: if (exe_ready) begin
                state_d    = IDLE;
                wb_valid_d = ~kill;
                wb_data_d  = kill ? wb_data_q : exe_result;
                acc_en     = ~kill & fpuf_q;
            end else if (kill) begin
                state_d = DRAIN;
            end
            DRAIN: state_d = exe_ready ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            exe_rm_q   <= '0;
            waddr_q    <= '0;
            wren_q     <= 1'b0;
            fwren_q    <= 1'b0;
            fpuf_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            exe_rm_q   <= exe_rm_d;
            waddr_q    <= waddr_d;
            wren_q     <= wren_d;
            fwren_q    <= fwren_d;
            fpuf_q     <= fpuf_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            illegal_q  <= illegal_d;
        end
    end

    // the execute unit sees the resolved rm in the start cycle, then the captured copy
    assign exe_enable = accept;
    assign exe_rm     = accept ? rr : exe_rm_q;
    assign wb_valid   = wb_valid_q;
    assign wb_data    = wb_data_q;
    assign wb_waddr   = waddr_q;
    assign wb_wren    = wb_valid_q & wren_q;
    assign wb_fwren   = wb_valid_q & fwren_q;
    assign illegal    = illegal_q;

    fp_csr_file u_csr (
        .clk       (clk),
        .rst       (rst),
        .csr_wen   (csr_wen),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .acc_en    (acc_en),
        .acc_flags (exe_flags),
        .frm       (frm),
        .fflags    (fflags),
        .csr_rdata (csr_rdata)
    );
endmodule

// File: tb/tb_fpu_sequencer.sv
// tb_fpu_sequencer: table vectors, directed corner sequences and randomized ops
// checked against an fcsr/latency model of the sequencer.
module tb_fpu_sequencer;
    logic        clk, rst;
    logic        issue_valid, issue_ready, issue_userm, issue_fpuf, issue_wren, issue_fwren;
    logic [2:0]  issue_rm, exe_rm, frm;
    logic [4:0]  issue_waddr, exe_flags, wb_waddr, fflags;
    logic        kill, exe_enable, exe_ready, wb_valid, wb_wren, wb_fwren, illegal, csr_wen;
    logic [31:0] exe_result, wb_data, csr_wdata, csr_rdata;
    logic [11:0] csr_addr;

    fpu_sequencer dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_userm(issue_userm), .issue_fpuf(issue_fpuf), .issue_rm(issue_rm),
        .issue_waddr(issue_waddr), .issue_wren(issue_wren), .issue_fwren(issue_fwren),
        .kill(kill), .exe_enable(exe_enable), .exe_rm(exe_rm), .exe_ready(exe_ready),
        .exe_result(exe_result), .exe_flags(exe_flags), .wb_valid(wb_valid),
        .wb_data(wb_data), .wb_waddr(wb_waddr), .wb_wren(wb_wren), .wb_fwren(wb_fwren),
        .illegal(illegal), .csr_wen(csr_wen), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .frm(frm), .fflags(fflags)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic [2:0] m_frm = 0;
    logic [4:0] m_ff = 0;

    typedef struct {logic [11:0] a; logic [31:0] d; logic [2:0] frm; logic [4:0] ff; logic [31:0] rd;} csr_vec_t;
    typedef struct {logic [2:0] frm; logic [2:0] rm; logic u; logic ill; logic [2:0] xrm;} rm_vec_t;
    csr_vec_t cv[6];
    rm_vec_t  rv[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        csr_wen = 1; csr_addr = a; csr_wdata = d;
        tick();
        csr_wen = 0;
        if (a == 12'h001) m_ff = d[4:0];
        if (a == 12'h002) m_frm = d[2:0];
        if (a == 12'h003) begin m_frm = d[7:5]; m_ff = d[4:0]; end
    endtask

    // one op: lat = cycles from handshake to exe_ready; kill_at = cycle after handshake to pulse kill (-1 none)
    task automatic do_op(input logic [2:0] rm, input logic userm, input logic fpuf, input logic [4:0] wa,
                         input logic wr, input logic fwr, input int lat, input logic [31:0] res,
                         input logic [4:0] fl, input int kill_at);
        logic [2:0] rr;
        logic bad_rm, killed;
        rr = (rm == 3'd7) ? m_frm : rm;
        bad_rm = userm && (rr >= 3'd5);
        killed = (kill_at >= 1) && (kill_at <= lat);
        issue_valid = 1; issue_rm = rm; issue_userm = userm; issue_fpuf = fpuf;
        issue_waddr = wa; issue_wren = wr; issue_fwren = fwr;
        exe_ready = (lat == 0); exe_result = res; exe_flags = fl;
        #4;
        check("issue_ready_hs", issue_ready, 1);
        check("exe_enable_hs", exe_enable, !bad_rm);
        if (!bad_rm) check("exe_rm_hs", exe_rm, rr);
        tick();
        issue_valid = 0; exe_ready = 0;
        if (bad_rm) begin
            #4;
            check("illegal_pulse", illegal, 1);
            check("illegal_no_wb", wb_valid, 0);
            check("illegal_ready", issue_ready, 1);
            check("illegal_no_en", exe_enable, 0);
            tick();
            check("illegal_drop", illegal, 0);
            return;
        end
        for (int c = 1; c <= lat; c++) begin
            exe_ready = (c == lat); kill = (c == kill_at);
            #4;
            check("wait_no_wb", wb_valid, 0);
            check("wait_not_ready", issue_ready, 0);
            check("wait_exe_rm", exe_rm, rr);
            tick();
        end
        exe_ready = 0; kill = 0;
        #4;
        if (killed) begin
            check("kill_no_wb", wb_valid, 0);
            check("kill_ready", issue_ready, 1);
        end else begin
            check("wb_valid", wb_valid, 1);
            check("wb_data", wb_data, res);
            check("wb_waddr", wb_waddr, wa);
            check("wb_wren", wb_wren, wr);
            check("wb_fwren", wb_fwren, fwr);
            if (fpuf) m_ff = m_ff | fl;
        end
        check("fflags_after_op", fflags, m_ff);
    endtask

    task automatic collide(input logic [11:0] a, input logic [31:0] d, input logic [4:0] exp_ff, input logic [2:0] exp_frm);
        issue_valid = 1; issue_userm = 0; issue_rm = 0; issue_fpuf = 1; issue_wren = 0; issue_fwren = 1;
        tick();
        issue_valid = 0; exe_ready = 1; exe_flags = 5'h08; exe_result = 32'h1234_5678;
        csr_wen = 1; csr_addr = a; csr_wdata = d;
        tick();
        exe_ready = 0; csr_wen = 0;
        #4;
        check("collide_wb", wb_valid, 1);
        check("collide_fflags", fflags, exp_ff);
        check("collide_frm", frm, exp_frm);
        m_ff = exp_ff; m_frm = exp_frm;
    endtask

    initial begin
        cv[0] = '{12'h003, 32'h0000_0FFF, 3'd7, 5'h1F, 32'h0000_00FF};
        cv[1] = '{12'h001, 32'h0000_000A, 3'd7, 5'h0A, 32'h0000_000A};
        cv[2] = '{12'h002, 32'h0000_003D, 3'd5, 5'h0A, 32'h0000_0005};
        cv[3] = '{12'h003, 32'h0000_0040, 3'd2, 5'h00, 32'h0000_0040};
        cv[4] = '{12'h004, 32'hFFFF_FFFF, 3'd2, 5'h00, 32'h0000_0000};
        cv[5] = '{12'h001, 32'hFFFF_FFE3, 3'd2, 5'h03, 32'h0000_0003};
        rv[0] = '{3'd0, 3'd3, 1'b1, 1'b0, 3'd3};
        rv[1] = '{3'd2, 3'd7, 1'b1, 1'b0, 3'd2};
        rv[2] = '{3'd5, 3'd7, 1'b1, 1'b1, 3'd0};
        rv[3] = '{3'd5, 3'd7, 1'b0, 1'b0, 3'd5};
        rv[4] = '{3'd0, 3'd6, 1'b1, 1'b1, 3'd0};
        rv[5] = '{3'd0, 3'd5, 1'b0, 1'b0, 3'd5};
        rv[6] = '{3'd4, 3'd7, 1'b1, 1'b0, 3'd4};
        rv[7] = '{3'd6, 3'd1, 1'b1, 1'b0, 3'd1};

        rst = 1; issue_valid = 0; issue_userm = 0; issue_fpuf = 0; issue_rm = 0; issue_waddr = 0;
        issue_wren = 0; issue_fwren = 0; kill = 0; exe_ready = 0; exe_result = 0; exe_flags = 0;
        csr_wen = 0; csr_addr = 0; csr_wdata = 0;
        #12;
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_wb_wren", wb_wren, 0);
        check("rst_exe_enable", exe_enable, 0);
        check("rst_illegal", illegal, 0);
        check("rst_exe_rm", exe_rm, 0);
        check("rst_frm", frm, 0);
        check("rst_fflags", fflags, 0);
        check("rst_ready", issue_ready, 1);
        rst = 0;
        tick();

        foreach (cv[i]) begin
            csr_write(cv[i].a, cv[i].d);
            csr_addr = cv[i].a;
            #1;
            check("csr_frm", frm, cv[i].frm);
            check("csr_fflags", fflags, cv[i].ff);
            check("csr_rdata", csr_rdata, cv[i].rd);
        end

        foreach (rv[i]) begin
            csr_write(12'h002, {29'b0, rv[i].frm});
            issue_valid = 1; issue_userm = rv[i].u; issue_rm = rv[i].rm; issue_fpuf = 0;
            exe_ready = 1; exe_result = 32'hA000_0000 + i;
            #4;
            check("rmtab_enable", exe_enable, !rv[i].ill);
            if (!rv[i].ill) check("rmtab_exe_rm", exe_rm, rv[i].xrm);
            tick();
            issue_valid = 0; exe_ready = 0;
            check("rmtab_illegal", illegal, rv[i].ill);
            check("rmtab_wb", wb_valid, !rv[i].ill);
            tick();
        end

        // dynamic rm from fcsr, 3-cycle execute
        csr_write(12'h003, 32'h040);
        do_op(3'd7, 1, 0, 5'd9, 0, 1, 3, 32'h3F80_0000, 5'h00, -1);
        tick();
        // invalid dynamic rm
        csr_write(12'h002, 32'd5);
        do_op(3'd7, 1, 1, 5'd1, 1, 0, 2, 32'h0, 5'h1F, -1);
        // flag accumulation
        csr_write(12'h003, 32'h040);
        do_op(3'd0, 1, 1, 5'd2, 0, 1, 1, 32'h1111_1111, 5'h01, -1);
        do_op(3'd1, 1, 1, 5'd3, 0, 1, 0, 32'h2222_2222, 5'h10, -1);
        csr_addr = 12'h003;
        #1;
        check("accum_fflags", fflags, 5'h11);
        check("accum_fcsr", csr_rdata, 32'h0000_0051);
        do_op(3'd2, 1, 0, 5'd4, 1, 0, 2, 32'h3333_3333, 5'h04, -1);
        check("nofpuf_fflags", fflags, 5'h11);
        tick();
        // CSR write colliding with completion
        collide(12'h001, 32'h0, 5'h00, 3'd2);
        tick();
        collide(12'h002, 32'h3, 5'h08, 3'd3);
        tick();
        // kill blocks acceptance in IDLE
        issue_valid = 1; issue_userm = 0; kill = 1;
        #4;
        check("kill_idle_ready", issue_ready, 0);
        check("kill_idle_enable", exe_enable, 0);
        tick();
        issue_valid = 0; kill = 0;
        // kill during a long divide
        do_op(3'd0, 1, 1, 5'd7, 0, 1, 12, 32'hDEAD_BEEF, 5'h1F, 2);
        check("kill_fflags", fflags, 5'h08);
        // back-to-back ops
        do_op(3'd0, 0, 1, 5'd5, 1, 0, 0, 32'h5555_0000, 5'h02, -1);
        do_op(3'd1, 0, 1, 5'd6, 0, 1, 2, 32'h6666_0000, 5'h04, -1);

        // randomized ops against the model
        for (int i = 0; i < 60; i++) begin
            int lat, ka;
            if (i % 7 == 0) csr_write(12'h002, $urandom);
            if ($urandom % 4 == 0) tick();
            lat = $urandom_range(0, 6);
            ka = (lat > 0 && $urandom % 5 == 0) ? $urandom_range(1, lat) : -1;
            do_op($urandom_range(0, 7), ($urandom % 4) != 0, $urandom % 2, $urandom_range(0, 31),
                  $urandom % 2, $urandom % 2, lat, $urandom, $urandom_range(0, 31), ka);
        end
        check("rand_frm", frm, m_frm);

        // async reset while a writeback beat is visible
        do_op(3'd0, 0, 1, 5'd12, 1, 1, 0, 32'hCAFE_F00D, 5'h1F, -1);
        #1 rst = 1;
        #1;
        check("arst_wb_valid", wb_valid, 0);
        check("arst_wb_wren", wb_wren, 0);
        check("arst_frm", frm, 0);
        check("arst_fflags", fflags, 0);
        m_ff = 0; m_frm = 0;
        #1 rst = 0;
        tick();
        // async reset mid-WAIT, then a stale exe_ready
        issue_valid = 1; issue_userm = 0; issue_rm = 3'd3; issue_wren = 1;
        tick();
        issue_valid = 0;
        tick();
        #2 rst = 1;
        #1;
        check("arst_wait_ready", issue_ready, 1);
        check("arst_wait_enable", exe_enable, 0);
        check("arst_wait_rm", exe_rm, 0);
        rst = 0;
        exe_ready = 1;
        tick();
        exe_ready = 0;
        #1;
        check("stale_no_wb", wb_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
